// File: rtl/checker_pkg.sv
// Shared types and default widths for the netlist result checker.
package checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int IN_W_DEF  = 20;
  localparam int OUT_W_DEF = 10;
  localparam int CNT_W_DEF = 16;

  function automatic logic is_active(input state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/result_checker_if.sv
// Valid/ready channel carrying one stimulus vector and both netlist outputs.
interface result_checker_if
  import checker_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_vec;
  logic [OUT_W-1:0] ref_out;
  logic [OUT_W-1:0] dut_out;

  modport master (output in_valid, in_vec, ref_out, dut_out, input in_ready);
  modport slave  (input in_valid, in_vec, ref_out, dut_out, output in_ready);

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX  = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // next count
  always_comb begin
    if (clr) begin
      cnt_d = ZERO;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/result_checker.sv
// Compares original vs reduced netlist outputs over a bounded run and keeps
// vector/error counts plus a snapshot of the first failing vector.
module result_checker
  import checker_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  result_checker_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [IN_W-1:0]  first_err_vec,
  output logic [OUT_W-1:0] first_err_diff
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [IN_W-1:0]  IN_ZERO  = {IN_W{1'b0}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_diff_q, s1_diff_d;
  logic [IN_W-1:0]  s1_vec_q, s1_vec_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [IN_W-1:0]  first_vec_q, first_vec_d;
  logic [OUT_W-1:0] first_diff_q, first_diff_d;

  logic [CNT_W-1:0] acc_cnt_s;
  logic             start_acc_s, xfer_s, last_xfer_s, s1_err_s;

  assign bus.in_ready = (state_q == RUN);
  assign start_acc_s  = start && ((state_q == IDLE) || (state_q == DONE));
  assign xfer_s       = bus.in_valid && bus.in_ready;
  assign last_xfer_s  = xfer_s && (acc_cnt_s == (num_q - CNT_ONE));
  assign s1_err_s     = s1_valid_q && (s1_diff_q != OUT_ZERO);

  sat_counter #(.W(CNT_W)) u_acc_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_s), .inc(xfer_s), .cnt(acc_cnt_s)
  );
  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_s), .inc(s1_valid_q), .cnt(vec_cnt)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst_n(rst_n), .clr(start_acc_s), .inc(s1_err_s), .cnt(err_cnt)
  );

  // compare stage load: only a real transfer refreshes the payload
  always_comb begin
    s1_valid_d = xfer_s;
    if (xfer_s) begin
      s1_diff_d = bus.ref_out ^ bus.dut_out;
      s1_vec_d  = bus.in_vec;
      s1_idx_d  = acc_cnt_s;
    end else begin
      s1_diff_d = s1_diff_q;
      s1_vec_d  = s1_vec_q;
      s1_idx_d  = s1_idx_q;
    end
  end

  // first-failure snapshot, frozen once found is set
  always_comb begin
    if (start_acc_s) begin
      found_d      = 1'b0;
      first_idx_d  = CNT_ZERO;
      first_vec_d  = IN_ZERO;
      first_diff_d = OUT_ZERO;
    end else if (s1_err_s && !found_q) begin
      found_d      = 1'b1;
      first_idx_d  = s1_idx_q;
      first_vec_d  = s1_vec_q;
      first_diff_d = s1_diff_q;
    end else begin
      found_d      = found_q;
      first_idx_d  = first_idx_q;
      first_vec_d  = first_vec_q;
      first_diff_d = first_diff_q;
    end
  end

  // run sequencing; DRAIN lasts until the last compare retires
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d   = num_vecs;
          state_d = (num_vecs == CNT_ZERO) ? DONE : RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (last_xfer_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_d) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = is_active(state_d);
    done_d = (state_d == DONE);
    pass_d = done_d && !found_d;
  end

  // all state and registered status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_q        <= CNT_ZERO;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= OUT_ZERO;
      s1_vec_q     <= IN_ZERO;
      s1_idx_q     <= CNT_ZERO;
      found_q      <= 1'b0;
      first_idx_q  <= CNT_ZERO;
      first_vec_q  <= IN_ZERO;
      first_diff_q <= OUT_ZERO;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      s1_valid_q   <= s1_valid_d;
      s1_diff_q    <= s1_diff_d;
      s1_vec_q     <= s1_vec_d;
      s1_idx_q     <= s1_idx_d;
      found_q      <= found_d;
      first_idx_q  <= first_idx_d;
      first_vec_q  <= first_vec_d;
      first_diff_q <= first_diff_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_vec  = first_vec_q;
  assign first_err_diff = first_diff_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: table of runs plus hand-built corner sequences,
// with a per-vector scoreboard and a 4-bit-counter instance for saturation.
module tb_result_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid;
  logic [15:0] num_vecs;
  logic [19:0] in_vec;
  logic [9:0]  ref_out, dut_out;

  always #5 clk = ~clk;

  result_checker_if #(.IN_W(20), .OUT_W(10)) bus16 ();
  result_checker_if #(.IN_W(20), .OUT_W(10)) bus4 ();

  assign bus16.in_valid = in_valid;
  assign bus16.in_vec   = in_vec;
  assign bus16.ref_out  = ref_out;
  assign bus16.dut_out  = dut_out;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_vec    = in_vec;
  assign bus4.ref_out   = ref_out;
  assign bus4.dut_out   = dut_out;

  logic        busy, done, pass;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic [19:0] first_err_vec;
  logic [9:0]  first_err_diff;
  logic        busy4, done4, pass4;
  logic [3:0]  vec4, err4, fidx4;
  logic [19:0] fvec4;
  logic [9:0]  fdiff4;

  result_checker #(.IN_W(20), .OUT_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs), .bus(bus16),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_vec(first_err_vec),
    .first_err_diff(first_err_diff)
  );

  result_checker #(.IN_W(20), .OUT_W(10), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs[3:0]), .bus(bus4),
    .busy(busy4), .done(done4), .pass(pass4), .vec_cnt(vec4), .err_cnt(err4),
    .first_err_idx(fidx4), .first_err_vec(fvec4), .first_err_diff(fdiff4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard entry: expected counters once a given transfer has retired
  typedef struct {
    int          due;
    logic [15:0] vc, ec, fi;
    logic [19:0] fv;
    logic [9:0]  fd;
  } sb_t;
  sb_t sbq[$];

  logic [15:0] m_acc, m_vc, m_ec, m_fi;
  logic [19:0] m_fv;
  logic [9:0]  m_fd;
  bit          m_found;

  task automatic model_reset();
    m_acc = 16'd0; m_vc = 16'd0; m_ec = 16'd0; m_fi = 16'd0;
    m_fv = 20'd0; m_fd = 10'd0; m_found = 1'b0;
  endtask

  always @(negedge clk) begin : sb_check
    sb_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("sb_vec_cnt", 32'(vec_cnt), 32'(e.vc));
      chk("sb_err_cnt", 32'(err_cnt), 32'(e.ec));
      chk("sb_first_idx", 32'(first_err_idx), 32'(e.fi));
      chk("sb_first_vec", 32'(first_err_vec), 32'(e.fv));
      chk("sb_first_diff", 32'(first_err_diff), 32'(e.fd));
    end
  end

  // drive one triple, hold until accepted, record expectation for N+2
  task automatic send(input logic [19:0] v, input logic [9:0] r, input logic [9:0] d);
    int t;
    logic [9:0] df;
    sb_t e;
    in_valid = 1'b1; in_vec = v; ref_out = r; dut_out = d; t = 0;
    @(negedge clk);
    while (!bus16.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus16.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout: in_ready never rose, got 0 expected 1 (t=%0t)", $time);
    end else begin
      df = r ^ d;
      m_vc++;
      if (df != 10'd0) begin
        if (m_ec != 16'hFFFF) m_ec++;
        if (!m_found) begin
          m_found = 1'b1; m_fi = m_acc; m_fv = v; m_fd = df;
        end
      end
      m_acc++;
      e.due = cyc + 2; e.vc = m_vc; e.ec = m_ec; e.fi = m_fi; e.fv = m_fv; e.fd = m_fd;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_vecs = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [19:0] vec_a[16];
  logic [9:0]  ref_a[16], dut_a[16];
  int          gap_a[16];

  task automatic fill(input int r, input logic [15:0] em, input logic [15:0] gm);
    for (int i = 0; i < 16; i++) begin
      vec_a[i] = 20'(r * 4096 + i * 17);
      ref_a[i] = 10'($urandom_range(0, 1023));
      dut_a[i] = ref_a[i] ^ (em[i] ? (10'h001 << (i % 10)) : 10'h000);
      gap_a[i] = gm[i] ? 1 : 0;
    end
  endtask

  // full run with start, optional mid-run start, and end-of-run timing checks
  task automatic run_seq(input int n, input bit hold, input int inj_at);
    model_reset();
    do_start(n);
    @(negedge clk);
    chk("start_clears_done", 32'(done), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_vec_cnt", 32'(vec_cnt), 0);
    chk("start_err_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == inj_at) do_start(3);
      repeat (gap_a[i]) begin
        @(posedge clk); #1;
      end
      send(vec_a[i], ref_a[i], dut_a[i]);
    end
    if (hold) in_valid = 1'b1;
    @(negedge clk);
    chk("drain_done", 32'(done), 0);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_ready", 32'(bus16.in_ready), 0);
    @(negedge clk);
    chk("done_at_n2", 32'(done), 1);
    chk("busy_off", 32'(busy), 0);
    chk("done_ready", 32'(bus16.in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [15:0] err_mask;
    logic [15:0] gap_mask;
    int          exp_err;
    logic        exp_pass;
    int          exp_fidx;
  } run_t;
  run_t tbl[4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 8,  err_mask: 16'h0000, gap_mask: 16'h0000, exp_err: 0,  exp_pass: 1'b1, exp_fidx: 0};
    tbl[1] = '{n: 5,  err_mask: 16'h0012, gap_mask: 16'h0006, exp_err: 2,  exp_pass: 1'b0, exp_fidx: 1};
    tbl[2] = '{n: 12, err_mask: 16'h0FFF, gap_mask: 16'h0000, exp_err: 12, exp_pass: 1'b0, exp_fidx: 0};
    tbl[3] = '{n: 1,  err_mask: 16'h0001, gap_mask: 16'h0000, exp_err: 1,  exp_pass: 1'b0, exp_fidx: 0};

    rst_n = 1'b0; start = 1'b0; num_vecs = 16'd0;
    in_valid = 1'b0; in_vec = 20'd0; ref_out = 10'd0; dut_out = 10'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus16.in_ready), 0);
    chk("rst_in_ready4", 32'(bus4.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_vec_cnt", 32'(vec_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first_vec", 32'(first_err_vec), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 4; r++) begin
      fill(r, tbl[r].err_mask, tbl[r].gap_mask);
      run_seq(tbl[r].n, 1'b0, -1);
      chk("tbl_pass", 32'(pass), 32'(tbl[r].exp_pass));
      chk("tbl_vec_cnt", 32'(vec_cnt), 32'(tbl[r].n));
      chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[r].exp_err));
      chk("tbl_first_idx", 32'(first_err_idx), 32'(tbl[r].exp_fidx));
    end

    // named first-failure snapshot
    fill(5, 16'h0000, 16'h0000);
    vec_a[3] = 20'h0A5F0; ref_a[3] = 10'h3C0; dut_a[3] = 10'h3C5;
    dut_a[5] = ref_a[5] ^ 10'h001;
    run_seq(6, 1'b0, -1);
    chk("snap_err_cnt", 32'(err_cnt), 2);
    chk("snap_first_idx", 32'(first_err_idx), 3);
    chk("snap_first_vec", 32'(first_err_vec), 32'h0A5F0);
    chk("snap_first_diff", 32'(first_err_diff), 32'h005);
    chk("snap_pass", 32'(pass), 0);

    // valid pattern 1,0,0,1,1,0,1 then valid held through DRAIN/DONE
    fill(6, 16'h0000, 16'h0000);
    gap_a[1] = 2; gap_a[3] = 1;
    run_seq(4, 1'b1, -1);
    chk("gap_vec_cnt", 32'(vec_cnt), 4);
    chk("gap_pass", 32'(pass), 1);

    // empty run, then a fresh run from DONE
    model_reset();
    do_start(0);
    @(negedge clk);
    chk("zero_done", 32'(done), 1);
    chk("zero_pass", 32'(pass), 1);
    chk("zero_vec_cnt", 32'(vec_cnt), 0);
    chk("zero_busy", 32'(busy), 0);
    @(posedge clk); #1;
    fill(7, 16'h0000, 16'h0000);
    run_seq(2, 1'b0, -1);
    chk("rerun_pass", 32'(pass), 1);
    chk("rerun_vec_cnt", 32'(vec_cnt), 2);

    // reset in the middle of a run that already logged an error
    fill(8, 16'h0002, 16'h0000);
    model_reset();
    do_start(10);
    for (int i = 0; i < 3; i++) send(vec_a[i], ref_a[i], dut_a[i]);
    @(negedge clk);
    chk("pre_rst_err", 32'(err_cnt), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus16.in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_vec", 32'(vec_cnt), 0);
    chk("mid_rst_err", 32'(err_cnt), 0);
    chk("mid_rst_fidx", 32'(first_err_idx), 0);
    chk("mid_rst_fdiff", 32'(first_err_diff), 0);
    @(posedge clk); #1;
    fill(9, 16'h0000, 16'h0000);
    run_seq(3, 1'b0, -1);
    chk("post_rst_pass", 32'(pass), 1);
    chk("post_rst_vec", 32'(vec_cnt), 3);

    // 4-bit counters: all vectors failing, ignored start mid-run, twice
    for (int k = 0; k < 2; k++) begin
      fill(10 + k, 16'h7FFF, 16'h0000);
      run_seq(15, 1'b0, (k == 0) ? 5 : -1);
      chk("sat_err4", 32'(err4), 15);
      chk("sat_vec4", 32'(vec4), 15);
      chk("sat_done4", 32'(done4), 1);
      chk("sat_busy4", 32'(busy4), 0);
      chk("sat_pass4", 32'(pass4), 0);
      chk("sat_fidx4", 32'(fidx4), 0);
      chk("sat_fvec4", 32'(fvec4), 32'(vec_a[0]));
      chk("sat_fdiff4", 32'(fdiff4), 32'h001);
      chk("sat_err16", 32'(err_cnt), 15);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
